// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection path: header layout, sequence width, packetizer states.
package noc_pkg;

  localparam int unsigned SEQ_W = 8;

  // Header field positions, expressed in units of one mesh coordinate width
  localparam int unsigned HDR_DX  = 0;
  localparam int unsigned HDR_DY  = 1;
  localparam int unsigned HDR_SX  = 2;
  localparam int unsigned HDR_SY  = 3;
  localparam int unsigned HDR_SEQ = 4;

  typedef logic [1:0] pkt_state_t;

  localparam pkt_state_t ST_IDLE = 2'd0;
  localparam pkt_state_t ST_PAY  = 2'd1;
  localparam pkt_state_t ST_DROP = 2'd2;

endpackage

// File: rtl/noc_skid.sv
// Two-entry AXI-Stream register slice; in_ready, out_valid and out_data all come straight from flops.
module noc_skid #(
  parameter int unsigned W = 37
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q;
  logic         vld_q;
  logic         push;
  logic         pop;

  assign push = in_valid_i & rdy_q;
  assign pop  = vld_q & out_ready_i;

  // head is the presented entry; tail only holds data while the slice is full
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = in_data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          tail_d = in_data_i;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= (cnt_d != 2'd2);
      vld_q  <= (cnt_d != 2'd0);
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = vld_q;
  assign out_data_o  = head_q;

endmodule

// File: rtl/noc_packetizer.sv
// NoC injection stage: prepends a routing header to each payload message and caps payload length.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int unsigned BW      = 32,
  parameter int unsigned BWB     = BW / 8,
  parameter int unsigned XY_SZ   = 3,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic             clk_line,
  input  logic             rst,
  input  logic [XY_SZ-1:0] myX,
  input  logic [XY_SZ-1:0] myY,
  input  logic [XY_SZ-1:0] dst_x,
  input  logic [XY_SZ-1:0] dst_y,
  input  logic             s_TVALID,
  input  logic             s_TLAST,
  input  logic [BW-1:0]    s_TDATA,
  input  logic [BWB-1:0]   s_TKEEP,
  output logic             s_TREADY,
  output logic             m_TVALID,
  output logic             m_TLAST,
  output logic [BW-1:0]    m_TDATA,
  output logic [BWB-1:0]   m_TKEEP,
  input  logic             m_TREADY,
  output logic             err_trunc
);

  localparam int unsigned PW    = BW + BWB + 1;
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  pkt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             err_q, err_d;
  logic             push;
  logic [PW-1:0]    push_data;
  logic [BW-1:0]    hdr;
  logic             skid_rdy;
  logic [PW-1:0]    skid_out;

  // Next-state and skid push; the header captures dst_x/dst_y directly into the skid entry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    err_d     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    hdr       = '0;
    hdr[HDR_DX*XY_SZ +: XY_SZ]  = dst_x;
    hdr[HDR_DY*XY_SZ +: XY_SZ]  = dst_y;
    hdr[HDR_SX*XY_SZ +: XY_SZ]  = myX;
    hdr[HDR_SY*XY_SZ +: XY_SZ]  = myY;
    hdr[HDR_SEQ*XY_SZ +: SEQ_W] = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (s_TVALID && skid_rdy) begin
          push      = 1'b1;
          push_data = {1'b0, {BWB{1'b1}}, hdr};
          seq_d     = seq_q + SEQ_W'(1);
          cnt_d     = '0;
          state_d   = ST_PAY;
        end
      end
      ST_PAY: begin
        if (s_TVALID && skid_rdy) begin
          push  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (s_TLAST) begin
            push_data = {1'b1, s_TKEEP, s_TDATA};
            state_d   = ST_IDLE;
          end else if (cnt_d == CNT_W'(MAX_LEN)) begin
            push_data = {1'b1, s_TKEEP, s_TDATA};
            err_d     = 1'b1;
            state_d   = ST_DROP;
          end else begin
            push_data = {1'b0, s_TKEEP, s_TDATA};
          end
        end
      end
      ST_DROP: begin
        if (s_TVALID && s_TLAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_line) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  noc_skid #(
    .W (PW)
  ) u_skid (
    .clk_i       (clk_line),
    .rst_i       (rst),
    .in_valid_i  (push),
    .in_data_i   (push_data),
    .in_ready_o  (skid_rdy),
    .out_valid_o (m_TVALID),
    .out_data_o  (skid_out),
    .out_ready_i (m_TREADY)
  );

  assign {m_TLAST, m_TKEEP, m_TDATA} = skid_out;
  assign s_TREADY  = ((state_q == ST_PAY) & skid_rdy) | (state_q == ST_DROP);
  assign err_trunc = err_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer built with MAX_LEN=4 so truncation is reachable with short messages.
module tb_noc_packetizer;

  logic        clk_line = 1'b0;
  logic        rst      = 1'b1;
  logic [2:0]  myX = '0, myY = '0, dst_x = '0, dst_y = '0;
  logic        s_TVALID = 1'b0, s_TLAST = 1'b0;
  logic [31:0] s_TDATA = '0;
  logic [3:0]  s_TKEEP = '0;
  logic        s_TREADY;
  logic        m_TVALID, m_TLAST;
  logic [31:0] m_TDATA;
  logic [3:0]  m_TKEEP;
  logic        m_TREADY = 1'b1;
  logic        err_trunc;

  noc_packetizer #(
    .BW(32), .BWB(4), .XY_SZ(3), .MAX_LEN(4)
  ) dut (
    .clk_line(clk_line), .rst(rst),
    .myX(myX), .myY(myY), .dst_x(dst_x), .dst_y(dst_y),
    .s_TVALID(s_TVALID), .s_TLAST(s_TLAST), .s_TDATA(s_TDATA), .s_TKEEP(s_TKEEP),
    .s_TREADY(s_TREADY),
    .m_TVALID(m_TVALID), .m_TLAST(m_TLAST), .m_TDATA(m_TDATA), .m_TKEEP(m_TKEEP),
    .m_TREADY(m_TREADY), .err_trunc(err_trunc)
  );

  always #5 clk_line = ~clk_line;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trunc_pulses = 0;
  logic [36:0] cap_q[$];
  int          cap_cyc[$];
  bit          stall_prev = 1'b0;
  logic [36:0] prev_flit;
  bit          bp_en = 1'b0;
  int          bp_cnt = 0;

  typedef struct {
    logic [2:0]  mx, my, dx, dy;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [31:0] exp_hdr;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_flit(input string nm, input int idx, input logic [31:0] d,
                          input logic last, input logic [3:0] keep);
    if (idx >= cap_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: flit %0d missing, got %0d flits", nm, idx, cap_q.size());
    end else begin
      chk(nm, 64'(cap_q[idx]), 64'({last, keep, d}));
    end
  endtask

  // Output monitor: records handshakes and checks that stalled flits hold steady
  always @(negedge clk_line) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!m_TVALID || {m_TLAST, m_TKEEP, m_TDATA} !== prev_flit) begin
          errors++;
          $display("FAIL stable: got v=%0b %0h expected v=1 %0h", m_TVALID,
                   {m_TLAST, m_TKEEP, m_TDATA}, prev_flit);
        end
      end
      if (m_TVALID && m_TREADY) begin
        cap_q.push_back({m_TLAST, m_TKEEP, m_TDATA});
        cap_cyc.push_back(cyc);
      end
      if (err_trunc) trunc_pulses++;
      stall_prev = m_TVALID && !m_TREADY;
      prev_flit  = {m_TLAST, m_TKEEP, m_TDATA};
    end
  end

  // Backpressure pattern 1,0,0,1 repeating
  always @(posedge clk_line) begin
    #1;
    if (bp_en) begin
      m_TREADY = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
      bp_cnt++;
    end
  end

  task automatic wait_acc();
    int b = 0;
    @(negedge clk_line);
    while (!s_TREADY && b < 200) begin
      @(negedge clk_line);
      b++;
    end
    if (!s_TREADY) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_TREADY=0 expected 1 within 200 cycles");
    end
    @(posedge clk_line);
    #1;
  endtask

  task automatic send(input int n, input logic [31:0] base, input bit hold);
    for (int i = 0; i < n; i++) begin
      s_TVALID = 1'b1;
      s_TDATA  = base + 32'(i);
      s_TKEEP  = 4'hF;
      s_TLAST  = (i == n - 1);
      wait_acc();
    end
    if (!hold) begin
      s_TVALID = 1'b0;
      s_TLAST  = 1'b0;
    end
  endtask

  task automatic wait_flits(input int n, input int budget);
    int b = 0;
    while (cap_q.size() < n && b < budget) begin
      @(negedge clk_line);
      b++;
    end
    if (cap_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL flit_timeout: got %0d flits expected %0d", cap_q.size(), n);
    end
  endtask

  initial begin
    tbl[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 32'hDEADBEEF, 4'hF, 32'h0000_0463};
    tbl[1] = '{3'd7, 3'd7, 3'd0, 3'd0, 32'h1234_5678, 4'hF, 32'h0000_1FC0};
    tbl[2] = '{3'd5, 3'd3, 3'd5, 3'd3, 32'hA5A5_0001, 4'hF, 32'h0000_275D};
    tbl[3] = '{3'd0, 3'd0, 3'd7, 3'd7, 32'hFFFF_FFFF, 4'h3, 32'h0000_303F};

    // Reset values
    repeat (3) @(posedge clk_line);
    @(negedge clk_line);
    chk("rst_m_tvalid", 64'(m_TVALID), 64'd0);
    chk("rst_m_tlast", 64'(m_TLAST), 64'd0);
    chk("rst_m_tdata", 64'(m_TDATA), 64'd0);
    chk("rst_m_tkeep", 64'(m_TKEEP), 64'd0);
    chk("rst_s_tready", 64'(s_TREADY), 64'd0);
    chk("rst_err_trunc", 64'(err_trunc), 64'd0);
    @(posedge clk_line);
    #1;
    rst = 1'b0;

    // Single-flit messages with exact cycle timing
    for (int v = 0; v < 4; v++) begin
      @(posedge clk_line);
      #1;
      myX = tbl[v].mx; myY = tbl[v].my; dst_x = tbl[v].dx; dst_y = tbl[v].dy;
      s_TVALID = 1'b1; s_TDATA = tbl[v].data; s_TKEEP = tbl[v].keep; s_TLAST = 1'b1;
      @(negedge clk_line);
      chk($sformatf("v%0d_idle_tready", v), 64'(s_TREADY), 64'd0);
      @(negedge clk_line);
      chk($sformatf("v%0d_hdr_valid", v), 64'(m_TVALID), 64'd1);
      chk($sformatf("v%0d_hdr", v), 64'({m_TLAST, m_TKEEP, m_TDATA}), 64'({1'b0, 4'hF, tbl[v].exp_hdr}));
      chk($sformatf("v%0d_pay_tready", v), 64'(s_TREADY), 64'd1);
      @(posedge clk_line);
      #1;
      s_TVALID = 1'b0; s_TLAST = 1'b0;
      dst_x = ~tbl[v].dx;
      @(negedge clk_line);
      chk($sformatf("v%0d_pay_valid", v), 64'(m_TVALID), 64'd1);
      chk($sformatf("v%0d_pay", v), 64'({m_TLAST, m_TKEEP, m_TDATA}), 64'({1'b1, tbl[v].keep, tbl[v].data}));
      @(negedge clk_line);
      chk($sformatf("v%0d_drained", v), 64'(m_TVALID), 64'd0);
      chk($sformatf("v%0d_back_idle", v), 64'(s_TREADY), 64'd0);
    end

    // 4-beat message under toggling backpressure (seq 4)
    myX = 3'd2; myY = 3'd1; dst_x = 3'd6; dst_y = 3'd5;
    cap_q.delete(); cap_cyc.delete();
    bp_en = 1'b1;
    send(4, 32'hB000_0000, 1'b0);
    wait_flits(5, 100);
    bp_en = 1'b0;
    @(posedge clk_line);
    #1;
    m_TREADY = 1'b1;
    repeat (3) @(negedge clk_line);
    chk("bp_count", 64'(cap_q.size()), 64'd5);
    chk_flit("bp_hdr", 0, 32'h0000_42AE, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++)
      chk_flit($sformatf("bp_pay%0d", i), i + 1, 32'hB000_0000 + 32'(i), i == 3, 4'hF);

    // 6-beat message truncated at 4 payload flits (seq 5)
    myX = 3'd3; myY = 3'd3; dst_x = 3'd1; dst_y = 3'd2;
    cap_q.delete(); cap_cyc.delete();
    trunc_pulses = 0;
    send(6, 32'hE000_0000, 1'b0);
    wait_flits(5, 100);
    repeat (5) @(negedge clk_line);
    chk("tr_count", 64'(cap_q.size()), 64'd5);
    chk_flit("tr_hdr", 0, 32'h0000_56D1, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++)
      chk_flit($sformatf("tr_pay%0d", i), i + 1, 32'hE000_0000 + 32'(i), i == 3, 4'hF);
    chk("tr_err_pulses", 64'(trunc_pulses), 64'd1);
    chk("tr_back_idle", 64'(s_TREADY), 64'd0);

    // Reset during the second payload beat of a 4-beat message
    myX = 3'd4; myY = 3'd4; dst_x = 3'd0; dst_y = 3'd1;
    s_TVALID = 1'b1; s_TDATA = 32'h7000_0000; s_TKEEP = 4'hF; s_TLAST = 1'b0;
    wait_acc();
    s_TDATA = 32'h7000_0001;
    rst = 1'b1;
    @(posedge clk_line);
    @(negedge clk_line);
    chk("mid_rst_m_tvalid", 64'(m_TVALID), 64'd0);
    chk("mid_rst_s_tready", 64'(s_TREADY), 64'd0);
    chk("mid_rst_m_tdata", 64'(m_TDATA), 64'd0);
    @(posedge clk_line);
    #1;
    rst = 1'b0;
    s_TVALID = 1'b0;

    // 257 back-to-back single-flit messages: seq restarts at 0 after reset and wraps
    myX = 3'd1; myY = 3'd1; dst_x = 3'd2; dst_y = 3'd2;
    cap_q.delete(); cap_cyc.delete();
    for (int i = 0; i < 257; i++) send(1, 32'hC000_0000 + 32'(i), 1'b1);
    s_TVALID = 1'b0; s_TLAST = 1'b0;
    wait_flits(514, 2000);
    repeat (3) @(negedge clk_line);
    chk("wrap_count", 64'(cap_q.size()), 64'd514);
    for (int i = 0; i < 257; i++) begin
      chk_flit($sformatf("wrap_hdr%0d", i), 2 * i, 32'h0000_0252 | (32'(i % 256) << 12), 1'b0, 4'hF);
      chk_flit($sformatf("wrap_pay%0d", i), 2 * i + 1, 32'hC000_0000 + 32'(i), 1'b1, 4'hF);
    end
    if (cap_cyc.size() == 514)
      chk("wrap_no_gaps", 64'(cap_cyc[513] - cap_cyc[0]), 64'd513);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
